// File: rtl/mem_access_unit.sv
// mem_access_unit: memory access stage of the 32-bit datapath.
// Holds MAR/MDR and runs single-word RAM read/write transactions over a
// req/ack handshake, with a bounded wait and a sticky error flag.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // The last wait-cycle count before the request is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;

  // Transaction FSM together with MAR, MDR, wait counter and error flag.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a start that coincides with a MAR load still drives the new address in
  // the next cycle because mem_addr is taken straight from mar.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      mar   <= '0;
      mdr   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mar_in) mar <= bus_in[ADDR_W-1:0];
          if (mdr_in) mdr <= bus_in;
          if (rd && wr) begin
            // Conflicting start: no bus cycle, just flag it and finish.
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (rd || wr) begin
            err_q <= 1'b0;
            cnt   <= '0;
            state <= rd ? S_RD : S_WR;
          end
        end
        S_RD, S_WR: begin
          if (mem_ack) begin
            if (state == S_RD) mdr <= mem_rdata;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;  // S_DONE lasts exactly one cycle
      endcase
    end
  end

  // Outputs decode state and registers only, so mem_ack never reaches an
  // output combinationally and clr clears them as soon as it asserts.
  assign mem_req   = (state == S_RD) || (state == S_WR);
  assign mem_we    = (state == S_WR);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mdr_out   = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              clr;
  logic [DATA_W-1:0] bus_in;
  logic              mar_in, mdr_in, rd, wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_req, mem_we, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mdr_out;

  int vectors = 0;
  int miscompares = 0;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .rd(rd), .wr(wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mdr_out(mdr_out), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Control flags packed as {mem_req, mem_we, busy, done, err}.
  function automatic logic [4:0] flags();
    return {mem_req, mem_we, busy, done, err};
  endfunction

  task automatic load_mar(input logic [DATA_W-1:0] v);
    bus_in = v; mar_in = 1'b1; tick(); mar_in = 1'b0;
  endtask

  task automatic load_mdr(input logic [DATA_W-1:0] v);
    bus_in = v; mdr_in = 1'b1; tick(); mdr_in = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; bus_in = '0; mar_in = 0; mdr_in = 0; rd = 0; wr = 0;
    mem_rdata = '0; mem_ack = 0;
    tick(); tick();
    vectors++;
    if ({flags(), mem_addr, mem_wdata, mdr_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: flags=%b addr=%h wdata=%h mdr=%h, need all 0",
               flags(), mem_addr, mem_wdata, mdr_out);
    end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_clr_mid_write();
    load_mdr(32'h1111_2222);
    load_mar(32'h0000_0033);
    wr = 1'b1; tick(); wr = 1'b0;
    vectors++;
    if (flags() !== 5'b11100) begin
      miscompares++;
      $display("FAIL clr_pre_write: flags=%b, need 11100", flags());
    end
    #2 clr = 1'b1;
    #1;
    vectors++;
    if ({flags(), mem_addr, mem_wdata, mdr_out} !== '0) begin
      miscompares++;
      $display("FAIL clr_async: flags=%b addr=%h wdata=%h mdr=%h, need all 0 before edge",
               flags(), mem_addr, mem_wdata, mdr_out);
    end
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_load();
    load_mar(32'h0000_01A5);
    vectors++;
    if (mem_addr !== 9'h1A5) begin
      miscompares++;
      $display("FAIL mar_load: mem_addr=%h, need 1a5", mem_addr);
    end
    load_mdr(32'hDEAD_BEEF);
    vectors++;
    if (mdr_out !== 32'hDEAD_BEEF || mem_wdata !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mdr_load: mdr_out=%h wdata=%h busy=%b, need deadbeef deadbeef 0",
               mdr_out, mem_wdata, busy);
    end
  endtask

  task automatic test_read_zero_wait();
    load_mar(32'h0000_0010);
    rd = 1'b1; tick(); rd = 1'b0;                 // cycle 1
    vectors++;
    if (flags() !== 5'b10100 || mem_addr !== 9'h010) begin
      miscompares++;
      $display("FAIL rd0_req: flags=%b addr=%h, need 10100 010", flags(), mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick(); mem_ack = 1'b0; mem_rdata = '0;       // cycle 2
    vectors++;
    if (flags() !== 5'b00110 || mdr_out !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL rd0_done: flags=%b mdr=%h, need 00110 12345678", flags(), mdr_out);
    end
    tick();                                       // cycle 3
    vectors++;
    if (flags() !== 5'b00000) begin
      miscompares++;
      $display("FAIL rd0_idle: flags=%b, need 00000", flags());
    end
  endtask

  task automatic test_write_wait();
    int bad = 0;
    int pulses = 0;
    load_mdr(32'hCAFE_F00D);
    load_mar(32'h0000_01FF);
    wr = 1'b1; tick(); wr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (flags() !== 5'b11100 || mem_addr !== 9'h1FF || mem_wdata !== 32'hCAFE_F00D)
        bad++;
      if (c == 4) mem_ack = 1'b1;
      mem_rdata = 32'h9999_9999;
      tick();
    end
    mem_ack = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL wr_hold: %0d unstable request cycles, need 0", bad);
    end
    for (int c = 0; c < 3; c++) begin
      if (done === 1'b1) pulses++;
      if (c == 0 && (mem_req !== 1'b0 || mdr_out !== 32'hCAFE_F00D)) bad++;
      tick();
    end
    vectors++;
    if (pulses !== 1 || bad !== 0) begin
      miscompares++;
      $display("FAIL wr_done: pulses=%0d errors=%0d, need 1 pulse 0 errors", pulses, bad);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    load_mdr(32'h0BAD_F00D);
    mem_ack = 1'b0;
    rd = 1'b1; tick(); rd = 1'b0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    vectors++;
    if (n !== TIMEOUT) begin
      miscompares++;
      $display("FAIL to_req_len: mem_req high %0d cycles, need %0d", n, TIMEOUT);
    end
    vectors++;
    if (flags() !== 5'b00111 || mdr_out !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL to_done: flags=%b mdr=%h, need 00111 0badf00d", flags(), mdr_out);
    end
    tick(); tick(); tick();
    vectors++;
    if (flags() !== 5'b00001) begin
      miscompares++;
      $display("FAIL to_sticky: flags=%b, need 00001", flags());
    end
    rd = 1'b1; tick(); rd = 1'b0;
    vectors++;
    if (flags() !== 5'b10100) begin
      miscompares++;
      $display("FAIL to_err_clear: flags=%b, need 10100", flags());
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick(); mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    bus_in = 32'h4444_5555; mdr_in = 1'b1; rd = 1'b1; wr = 1'b1;
    tick(); mdr_in = 1'b0; rd = 1'b0; wr = 1'b0;
    vectors++;
    if (flags() !== 5'b00111 || mdr_out !== 32'h4444_5555) begin
      miscompares++;
      $display("FAIL conflict_done: flags=%b mdr=%h, need 00111 44445555", flags(), mdr_out);
    end
    tick();
    vectors++;
    if (flags() !== 5'b00001) begin
      miscompares++;
      $display("FAIL conflict_idle: flags=%b, need 00001", flags());
    end
  endtask

  task automatic test_same_cycle_and_ignore();
    bus_in = 32'h0000_00AB; mar_in = 1'b1; rd = 1'b1;
    tick();
    vectors++;
    if (mem_addr !== 9'h0AB || flags() !== 5'b10100) begin
      miscompares++;
      $display("FAIL same_cycle_addr: addr=%h flags=%b, need 0ab 10100", mem_addr, flags());
    end
    bus_in = 32'hFFFF_FFFF; mdr_in = 1'b1; wr = 1'b1;  // rd and mar_in still high
    tick(); mar_in = 1'b0; mdr_in = 1'b0; rd = 1'b0; wr = 1'b0;
    vectors++;
    if (mem_addr !== 9'h0AB || mdr_out !== 32'h4444_5555 || flags() !== 5'b10100) begin
      miscompares++;
      $display("FAIL rd_ignore: addr=%h mdr=%h flags=%b, need 0ab 44445555 10100",
               mem_addr, mdr_out, flags());
    end
    mem_ack = 1'b1; mem_rdata = 32'h55AA_33CC;
    tick(); mem_ack = 1'b0;
    vectors++;
    if (mdr_out !== 32'h55AA_33CC || done !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_ignore_done: mdr=%h done=%b, need 55aa33cc 1", mdr_out, done);
    end
    tick();
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick(); mem_ack = 1'b0;
    vectors++;
    if (flags() !== 5'b00000 || mdr_out !== 32'h55AA_33CC) begin
      miscompares++;
      $display("FAIL ack_idle: flags=%b mdr=%h, need 00000 55aa33cc", flags(), mdr_out);
    end
    rd = 1'b1; tick(); rd = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
    tick();                                       // DONE, ack held high
    mem_rdata = 32'h0506_0708;
    tick(); mem_ack = 1'b0;
    vectors++;
    if (flags() !== 5'b00000 || mdr_out !== 32'h0102_0304) begin
      miscompares++;
      $display("FAIL ack_done: flags=%b mdr=%h, need 00000 01020304", flags(), mdr_out);
    end
  endtask

  task automatic test_back_to_back();
    load_mar(32'h0000_0100);
    wr = 1'b1; tick(); wr = 1'b0;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;       // DONE
    tick();                                       // first IDLE cycle
    rd = 1'b1; tick(); rd = 1'b0;
    vectors++;
    if (flags() !== 5'b10100 || mem_addr !== 9'h100) begin
      miscompares++;
      $display("FAIL b2b_start: flags=%b addr=%h, need 10100 100", flags(), mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000;
    tick(); mem_ack = 1'b0;
    tick();
    vectors++;
    if (flags() !== 5'b00000 || mdr_out !== 32'hA5A5_0000) begin
      miscompares++;
      $display("FAIL b2b_end: flags=%b mdr=%h, need 00000 a5a50000", flags(), mdr_out);
    end
  endtask

  initial begin
    test_reset();
    test_clr_mid_write();
    test_load();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_conflict();
    test_same_cycle_and_ignore();
    test_stray_ack();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
